// File: rtl/wb_cmd_initiator.sv
// Single-outstanding command-to-Wishbone (classic cycle) initiator with retry handling.
// Optional per-access timeout enabled by defining WB_CMD_INITIATOR_TIMEOUT_EN.
module wb_cmd_initiator #(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,

    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i,
    input  logic [31:0] wbm_dat_i
);

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_cmd_initiator: TIMEOUT out of range 1..65535");
    end
    if (MAX_RETRY > 15) begin : g_bad_retry
        $error("wb_cmd_initiator: MAX_RETRY out of range 0..15");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_t;

    state_t      state, state_d;
    logic        ready_en;
    logic        gap, gap_d;
    logic [3:0]  retry_cnt, retry_d;
    logic        accept;
    logic        cyc;

    logic        we_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [3:0]  sel_q;

    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;

`ifdef WB_CMD_INITIATOR_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] to_cnt, to_d;
    logic        to_hit;

    assign to_hit = (to_cnt >= TO_LAST);
`endif

    // The one-cycle retry gap is a flag inside BUS rather than its own state.
    always_comb begin
        state_d   = state;
        gap_d     = gap;
        retry_d   = retry_cnt;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        accept    = 1'b0;
`ifdef WB_CMD_INITIATOR_TIMEOUT_EN
        to_d      = to_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (cmd_valid && ready_en) begin
                    accept    = 1'b1;
                    retry_d   = '0;
                    gap_d     = 1'b0;
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b0;
`ifdef WB_CMD_INITIATOR_TIMEOUT_EN
                    to_d      = '0;
`endif
                    state_d   = S_BUS;
                end
            end
            S_BUS: begin
                if (gap) begin
                    gap_d = 1'b0;
                end else if (wbm_err_i) begin
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b1;
                    state_d   = S_RESP;
                end else if (wbm_ack_i) begin
                    rsp_dat_d = we_q ? '0 : wbm_dat_i;
                    rsp_err_d = 1'b0;
                    state_d   = S_RESP;
                end else if (wbm_rty_i) begin
                    if (retry_cnt < 4'(MAX_RETRY)) begin
                        retry_d = retry_cnt + 4'd1;
                        gap_d   = 1'b1;
`ifdef WB_CMD_INITIATOR_TIMEOUT_EN
                        to_d    = '0;
`endif
                    end else begin
                        rsp_dat_d = '0;
                        rsp_err_d = 1'b1;
                        state_d   = S_RESP;
                    end
                end
`ifdef WB_CMD_INITIATOR_TIMEOUT_EN
                else if (to_hit) begin
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b1;
                    state_d   = S_RESP;
                end else if (to_cnt != '1) begin
                    to_d = to_cnt + 16'd1;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ready_en  <= 1'b0;
            gap       <= 1'b0;
            retry_cnt <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
`ifdef WB_CMD_INITIATOR_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            state     <= state_d;
            ready_en  <= 1'b1;
            gap       <= gap_d;
            retry_cnt <= retry_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
`ifdef WB_CMD_INITIATOR_TIMEOUT_EN
            to_cnt    <= to_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
            sel_q <= '0;
        end else if (accept) begin
            we_q  <= cmd_we;
            adr_q <= cmd_adr;
            dat_q <= cmd_dat;
            sel_q <= cmd_sel;
        end
    end

    // Derived from the async-reset state so cyc falls the moment rst_n drops.
    assign cyc       = (state == S_BUS) && !gap;
    assign wbm_cyc_o = cyc;
    assign wbm_stb_o = cyc;
    assign wbm_we_o  = cyc & we_q;
    assign wbm_adr_o = cyc ? adr_q : '0;
    assign wbm_dat_o = cyc ? dat_q : '0;
    assign wbm_sel_o = cyc ? sel_q : '0;
    assign wbm_cti_o = 3'b000;
    assign wbm_bte_o = 2'b00;

    assign cmd_ready = ready_en && (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed self-checking bench for wb_cmd_initiator (TIMEOUT=10, MAX_RETRY=3).
module tb_wb_cmd_initiator;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        wbm_rty_i;
    logic [31:0] wbm_dat_i;

    int unsigned passed = 0;
    int unsigned failed = 0;
    int unsigned total  = 0;

    wb_cmd_initiator #(.TIMEOUT(10), .MAX_RETRY(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_cti_o (wbm_cti_o),
        .wbm_bte_o (wbm_bte_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_err_i (wbm_err_i),
        .wbm_rty_i (wbm_rty_i),
        .wbm_dat_i (wbm_dat_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        check("issue_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_done_valid", 32'(rsp_valid), 32'd0);
        check("rsp_done_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int unsigned bad;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b0;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_rty_i = 1'b0;
        wbm_dat_i = '0;

        // Reset state
        #2;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_dat", rsp_dat, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_adr", wbm_adr_o, 32'h0);
        check("rst_cti_bte", {27'd0, wbm_cti_o, wbm_bte_o}, 32'd0);
        tick();
        check("rst_hold_cmd_ready", 32'(cmd_ready), 32'd0);
        #2 rst_n = 1'b1;
        #1 check("rel_before_edge_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        check("rel_first_edge_cmd_ready", 32'(cmd_ready), 32'd1);

        // Single write, ack on first strobe
        issue(1'b1, 32'h0000_0004, 32'h0000_00A5, 4'hF);
        check("wr_cyc", 32'(wbm_cyc_o), 32'd1);
        check("wr_stb", 32'(wbm_stb_o), 32'd1);
        check("wr_we", 32'(wbm_we_o), 32'd1);
        check("wr_adr", wbm_adr_o, 32'h0000_0004);
        check("wr_dat", wbm_dat_o, 32'h0000_00A5);
        check("wr_sel", 32'(wbm_sel_o), 32'hF);
        check("wr_cmd_ready_bus", 32'(cmd_ready), 32'd0);
        check("wr_rsp_valid_bus", 32'(rsp_valid), 32'd0);
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        check("wr_cyc_after_ack", 32'(wbm_cyc_o), 32'd0);
        check("wr_adr_idle", wbm_adr_o, 32'h0);
        check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        check("wr_rsp_err", 32'(rsp_err), 32'd0);
        check("wr_rsp_dat", rsp_dat, 32'h0);
        finish_rsp();

        // Read with 3 wait states
        issue(1'b0, 32'h0000_0008, 32'h1111_2222, 4'hF);
        for (int i = 0; i < 3; i++) begin
            check("rd_wait_stb", 32'(wbm_stb_o), 32'd1);
            check("rd_wait_adr", wbm_adr_o, 32'h0000_0008);
            check("rd_wait_we", 32'(wbm_we_o), 32'd0);
            tick();
        end
        check("rd_stb_4th", 32'(wbm_stb_o), 32'd1);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hDEAD_BEEF;
        tick();
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;
        check("rd_cyc_after_ack", 32'(wbm_cyc_o), 32'd0);
        check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd_rsp_dat", rsp_dat, 32'hDEAD_BEEF);
        check("rd_rsp_err", 32'(rsp_err), 32'd0);
        finish_rsp();

        // Retry exhaustion: 4 strobe bursts, 1-cycle gaps, then error
        issue(1'b1, 32'h0000_0010, 32'h0000_0055, 4'h3);
        for (int b = 0; b < 4; b++) begin
            check("rty_burst_cyc", 32'(wbm_cyc_o), 32'd1);
            check("rty_burst_adr", wbm_adr_o, 32'h0000_0010);
            check("rty_burst_sel", 32'(wbm_sel_o), 32'h3);
            wbm_rty_i = 1'b1;
            tick();
            wbm_rty_i = 1'b0;
            if (b < 3) begin
                check("rty_gap_cyc", 32'(wbm_cyc_o), 32'd0);
                check("rty_gap_adr", wbm_adr_o, 32'h0);
                check("rty_gap_rsp_valid", 32'(rsp_valid), 32'd0);
                tick();
            end
        end
        check("rty_end_cyc", 32'(wbm_cyc_o), 32'd0);
        check("rty_end_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rty_end_rsp_err", 32'(rsp_err), 32'd1);
        check("rty_end_rsp_dat", rsp_dat, 32'h0);
        finish_rsp();

        // ack+err together: err wins; response held under backpressure
        issue(1'b0, 32'h0000_0020, 32'h0, 4'hF);
        wbm_ack_i = 1'b1;
        wbm_err_i = 1'b1;
        wbm_dat_i = 32'h1234_5678;
        tick();
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = '0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_err", 32'(rsp_err), 32'd1);
            check("bp_rsp_dat", rsp_dat, 32'h0);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            tick();
        end
        cmd_valid = 1'b0;
        finish_rsp();

        // ack+rty together: ack wins, read data returned
        issue(1'b0, 32'h0000_0030, 32'h0, 4'hF);
        wbm_ack_i = 1'b1;
        wbm_rty_i = 1'b1;
        wbm_dat_i = 32'hCAFE_F00D;
        tick();
        wbm_ack_i = 1'b0;
        wbm_rty_i = 1'b0;
        wbm_dat_i = '0;
        check("ackrty_rsp_valid", 32'(rsp_valid), 32'd1);
        check("ackrty_rsp_err", 32'(rsp_err), 32'd0);
        check("ackrty_rsp_dat", rsp_dat, 32'hCAFE_F00D);
        finish_rsp();

        // Silent slave
        issue(1'b0, 32'h0000_0040, 32'h0, 4'hF);
`ifdef WB_CMD_INITIATOR_TIMEOUT_EN
        for (int i = 0; i < 10; i++) begin
            check("to_cyc_high", 32'(wbm_cyc_o), 32'd1);
            tick();
        end
        check("to_cyc_dropped", 32'(wbm_cyc_o), 32'd0);
        check("to_rsp_valid", 32'(rsp_valid), 32'd1);
        check("to_rsp_err", 32'(rsp_err), 32'd1);
        check("to_rsp_dat", rsp_dat, 32'h0);
        finish_rsp();
`else
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (wbm_cyc_o !== 1'b1 || rsp_valid !== 1'b0) bad++;
            tick();
        end
        check("noto_cyc_held_1000", bad, 32'd0);
        check("noto_cyc_still_high", 32'(wbm_cyc_o), 32'd1);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
`endif

        // Reset pulsed during BUS
        issue(1'b1, 32'h0000_0050, 32'h0000_0077, 4'hF);
        check("mr_cyc_before", 32'(wbm_cyc_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_cyc_async", 32'(wbm_cyc_o), 32'd0);
        check("mr_adr_async", wbm_adr_o, 32'h0);
        check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mr_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        #2 rst_n = 1'b1;
        #1 check("mr_rel_cmd_ready_pre", 32'(cmd_ready), 32'd0);
        tick();
        check("mr_rel_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mr_rel_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mr_rel_cyc", 32'(wbm_cyc_o), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
